// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the core run controller: command opcodes, controller
// states and small state-classification helpers.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_RUN   = 2'b01,
    OP_STOP  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

  // States in which a new LOAD/RUN/CLEAR may start.
  function automatic logic is_rest_state(input ctrl_state_e st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

  // States that present cmd_ready; LOAD and CLEAR are short fixed sequences.
  function automatic logic is_ready_state(input ctrl_state_e st);
    return (st == ST_IDLE) || (st == ST_RUN) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Command channel of the core run controller (valid/ready handshake).
interface core_run_ctrl_if
  import core_ctrl_pkg::*;
#(
  parameter int IMEM_AW = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  cmd_op_e            cmd_op;
  logic [IMEM_AW-1:0] cmd_addr;
  logic [31:0]        cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_addr, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_addr, cmd_data, output cmd_ready);
endinterface

// File: rtl/run_budget_counter.sv
// Remaining-budget down-counter paired with the run-cycle up-counter.
// expire flags the edge on which the last budgeted run_pc cycle is counted.
module run_budget_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] N,
  input  logic        enable,
  output logic        expire,
  output logic [31:0] count
);

  logic [31:0] remaining_r;
  logic [31:0] count_r;

  assign expire = enable && (remaining_r == 32'd1);
  assign count  = count_r;

  // Load a fresh budget (clearing the count) or step both counters per enabled cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining_r <= 32'd0;
      count_r     <= 32'd0;
    end else if (load) begin
      remaining_r <= N;
      count_r     <= 32'd0;
    end else if (enable) begin
      remaining_r <= remaining_r - 32'd1;
      count_r     <= count_r + 32'd1;
    end else begin
      remaining_r <= remaining_r;
      count_r     <= count_r;
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Core run controller: loads instruction words, runs the datapath for a
// cycle budget, stops on request and pulses the data-memory reset on CLEAR.
// Registered outputs are decodes of the next state, so each one changes on
// the same edge the controller enters or leaves the matching state.
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int IMEM_AW    = 4,
  parameter int CLR_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  core_run_ctrl_if.slave     cmd,
  output logic               instruction_write,
  output logic [IMEM_AW-1:0] instruction_addr,
  output logic [31:0]        instruction_data,
  output logic               run_pc,
  output logic               mem_reset_n,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        cycle_count
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  ctrl_state_e        state_r;
  ctrl_state_e        state_nxt_s;
  logic [CLR_W-1:0]   clr_cnt_r;
  logic [CLR_W-1:0]   clr_cnt_nxt_s;
  cmd_op_e            op_s;
  logic               accept_s;
  logic               err_set_s;
  logic               err_clr_s;
  logic               budget_load_s;
  logic               budget_expire_s;
  logic               load_cap_s;

  logic               run_pc_s;
  logic               iw_s;
  logic               mem_reset_n_s;
  logic               done_s;
  logic               err_s;
  logic [IMEM_AW-1:0] iaddr_s;
  logic [31:0]        idata_s;

  logic               run_pc_r;
  logic               iw_r;
  logic               mem_reset_n_r;
  logic               done_r;
  logic               err_r;
  logic [IMEM_AW-1:0] iaddr_r;
  logic [31:0]        idata_r;

  // Ready is withheld while reset is asserted even though the state reads IDLE.
  assign cmd.cmd_ready = reset_n && is_ready_state(state_r);
  assign busy          = (state_r == ST_LOAD) || (state_r == ST_RUN) || (state_r == ST_CLEAR);
  assign accept_s      = cmd.cmd_valid && cmd.cmd_ready;
  assign op_s          = cmd.cmd_op;

  assign instruction_write = iw_r;
  assign instruction_addr  = iaddr_r;
  assign instruction_data  = idata_r;
  assign run_pc            = run_pc_r;
  assign mem_reset_n       = mem_reset_n_r;
  assign done              = done_r;
  assign err               = err_r;

  run_budget_counter u_budget (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (budget_load_s),
    .N       (cmd.cmd_data),
    .enable  (run_pc_r),
    .expire  (budget_expire_s),
    .count   (cycle_count)
  );

  // State register and CLEAR hold counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      clr_cnt_r <= {CLR_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Next-state decode; commands that arrive mid-run other than STOP are flagged and dropped.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    err_set_s     = 1'b0;
    err_clr_s     = 1'b0;
    budget_load_s = 1'b0;
    load_cap_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s && is_rest_state(state_r)) begin
          case (op_s)
            OP_LOAD: begin
              state_nxt_s = ST_LOAD;
              load_cap_s  = 1'b1;
            end
            OP_RUN: begin
              budget_load_s = 1'b1;
              if (cmd.cmd_data != 32'd0) begin
                state_nxt_s = ST_RUN;
              end else begin
                state_nxt_s = ST_DONE;
              end
            end
            OP_CLEAR: begin
              state_nxt_s   = ST_CLEAR;
              clr_cnt_nxt_s = CLR_W'(CLR_CYCLES - 1);
              err_clr_s     = 1'b1;
            end
            default: begin
              state_nxt_s = state_r;
            end
          endcase
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && (op_s != OP_STOP)) begin
          err_set_s = 1'b1;
        end else begin
          err_set_s = 1'b0;
        end
        if (budget_expire_s || (accept_s && (op_s == OP_STOP))) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_r == {CLR_W{1'b0}}) begin
          state_nxt_s = ST_IDLE;
        end else begin
          clr_cnt_nxt_s = clr_cnt_r - CLR_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: next-cycle values of every registered output.
  always_comb begin
    run_pc_s      = (state_nxt_s == ST_RUN);
    iw_s          = (state_nxt_s == ST_LOAD);
    mem_reset_n_s = (state_nxt_s != ST_CLEAR);
    done_s        = (state_nxt_s == ST_DONE);
    if (err_clr_s) begin
      err_s = 1'b0;
    end else if (err_set_s) begin
      err_s = 1'b1;
    end else begin
      err_s = err_r;
    end
    if (load_cap_s) begin
      iaddr_s = cmd.cmd_addr;
      idata_s = cmd.cmd_data;
    end else begin
      iaddr_s = iaddr_r;
      idata_s = idata_r;
    end
  end

  // Output registers; reset drops run_pc and the write strobe immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_pc_r      <= 1'b0;
      iw_r          <= 1'b0;
      mem_reset_n_r <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      iaddr_r       <= {IMEM_AW{1'b0}};
      idata_r       <= 32'd0;
    end else begin
      run_pc_r      <= run_pc_s;
      iw_r          <= iw_s;
      mem_reset_n_r <= mem_reset_n_s;
      done_r        <= done_s;
      err_r         <= err_s;
      iaddr_r       <= iaddr_s;
      idata_r       <= idata_s;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Testbench for core_run_ctrl: directed vector table, multi-cycle corner
// sequences and randomized commands checked against a transaction-level model.
module tb_core_run_ctrl;
  import core_ctrl_pkg::*;

  localparam int AW  = 4;
  localparam int CLR = 2;

  logic          clk;
  logic          reset_n;
  logic          instruction_write;
  logic [AW-1:0] instruction_addr;
  logic [31:0]   instruction_data;
  logic          run_pc;
  logic          mem_reset_n;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   cycle_count;

  int checks;
  int errors;

  core_run_ctrl_if #(.IMEM_AW(AW)) bus ();

  core_run_ctrl #(.IMEM_AW(AW), .CLR_CYCLES(CLR)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cmd               (bus),
    .instruction_write (instruction_write),
    .instruction_addr  (instruction_addr),
    .instruction_data  (instruction_data),
    .run_pc            (run_pc),
    .mem_reset_n       (mem_reset_n),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .cycle_count       (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_LOADING, M_RUNNING, M_CLEARING, M_FINISHED} mmode_e;
  mmode_e      m_mode;
  longint      m_left;   // run_pc cycles still owed, including the current one
  int          m_clr;    // mem_reset_n low cycles still owed
  logic [31:0] m_cc;
  logic        m_err;
  logic [3:0]  m_iaddr;
  logic [31:0] m_idata;

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_clr = 0; m_cc = 32'd0;
    m_err = 1'b0; m_iaddr = 4'd0; m_idata = 32'd0;
  endtask

  function automatic logic m_ready();
    return (m_mode == M_IDLE) || (m_mode == M_RUNNING) || (m_mode == M_FINISHED);
  endfunction

  task automatic model_edge(input logic v, input cmd_op_e op, input logic [3:0] a, input logic [31:0] d);
    logic acc;
    acc = v && m_ready();
    case (m_mode)
      M_RUNNING: begin
        m_cc = m_cc + 32'd1;
        m_left = m_left - 1;
        if (acc) begin
          if (op == OP_STOP) m_left = 0;
          else m_err = 1'b1;
        end
        if (m_left == 0) m_mode = M_FINISHED;
      end
      M_LOADING: m_mode = M_IDLE;
      M_CLEARING: begin
        m_clr = m_clr - 1;
        if (m_clr == 0) m_mode = M_IDLE;
      end
      default: begin
        if (acc) begin
          case (op)
            OP_LOAD: begin m_mode = M_LOADING; m_iaddr = a; m_idata = d; end
            OP_RUN: begin
              m_cc = 32'd0;
              if (d == 32'd0) m_mode = M_FINISHED;
              else begin m_left = longint'(d); m_mode = M_RUNNING; end
            end
            OP_CLEAR: begin m_err = 1'b0; m_clr = CLR; m_mode = M_CLEARING; end
            default: ;
          endcase
        end
      end
    endcase
  endtask

  // ---------------- check helpers ----------------
  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk1({tag, ".ready"}, bus.cmd_ready, m_ready());
    chk1({tag, ".iw"},    instruction_write, m_mode == M_LOADING);
    chk1({tag, ".run"},   run_pc, m_mode == M_RUNNING);
    chk1({tag, ".mrn"},   mem_reset_n, m_mode != M_CLEARING);
    chk1({tag, ".busy"},  busy, (m_mode == M_LOADING) || (m_mode == M_RUNNING) || (m_mode == M_CLEARING));
    chk1({tag, ".done"},  done, m_mode == M_FINISHED);
    chk1({tag, ".err"},   err, m_err);
    chk32({tag, ".iaddr"}, {28'd0, instruction_addr}, {28'd0, m_iaddr});
    chk32({tag, ".idata"}, instruction_data, m_idata);
    chk32({tag, ".cc"},    cycle_count, m_cc);
    chk1({tag, ".excl"},  run_pc & instruction_write, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk1({tag, ".ready"}, bus.cmd_ready, 1'b0);
    chk1({tag, ".iw"},    instruction_write, 1'b0);
    chk1({tag, ".run"},   run_pc, 1'b0);
    chk1({tag, ".mrn"},   mem_reset_n, 1'b0);
    chk1({tag, ".busy"},  busy, 1'b0);
    chk1({tag, ".done"},  done, 1'b0);
    chk1({tag, ".err"},   err, 1'b0);
    chk32({tag, ".iaddr"}, {28'd0, instruction_addr}, 32'd0);
    chk32({tag, ".idata"}, instruction_data, 32'd0);
    chk32({tag, ".cc"},    cycle_count, 32'd0);
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare #1 later.
  task automatic step(input logic v, input cmd_op_e op, input logic [3:0] a, input logic [31:0] d,
                      input string tag);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    @(posedge clk);
    model_edge(v, op, a, d);
    #1;
    check_model(tag);
  endtask

  // Assert reset between edges, check asynchronous values, release on a falling edge.
  task automatic do_reset_mid(input string tag);
    #3;
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    check_reset_vals(tag);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, OP_LOAD, 4'd0, 32'd0, {tag, ".rel"});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        v;
    logic [1:0]  op;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        e_ready, e_iw, e_run, e_mrn, e_busy, e_done, e_err;
    logic [3:0]  e_iaddr;
    logic [31:0] e_idata;
    logic [31:0] e_cc;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int highs;
    cmd_op_e rop;
    logic rv;
    logic [31:0] rd;

    checks = 0;
    errors = 0;
    //              v    op     addr  data           rdy  iw   run  mrn  busy done err  iaddr id            cc
    tbl[0]  = '{1'b0, 2'b00, 4'd0, 32'd0,         1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'd3*4'd0, 32'd0, 32'd0};
    tbl[1]  = '{1'b1, 2'b00, 4'd3, 32'h00500093,  1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 4'd3, 32'h00500093, 32'd0};
    tbl[2]  = '{1'b0, 2'b00, 4'd0, 32'd0,         1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'd3, 32'h00500093, 32'd0};
    tbl[3]  = '{1'b1, 2'b01, 4'd0, 32'd0,         1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 4'd3, 32'h00500093, 32'd0};
    tbl[4]  = '{1'b1, 2'b10, 4'd0, 32'd0,         1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 4'd3, 32'h00500093, 32'd0};
    tbl[5]  = '{1'b0, 2'b00, 4'd0, 32'd0,         1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 4'd3, 32'h00500093, 32'd0};
    tbl[6]  = '{1'b1, 2'b01, 4'd0, 32'd2,         1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 4'd3, 32'h00500093, 32'd0};
    tbl[7]  = '{1'b1, 2'b00, 4'd5, 32'hDEADBEEF,  1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1, 4'd3, 32'h00500093, 32'd1};
    tbl[8]  = '{1'b0, 2'b00, 4'd0, 32'd0,         1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 4'd3, 32'h00500093, 32'd2};
    tbl[9]  = '{1'b1, 2'b11, 4'd0, 32'd0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 4'd3, 32'h00500093, 32'd2};
    tbl[10] = '{1'b1, 2'b00, 4'd9, 32'h00001234,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 4'd3, 32'h00500093, 32'd2};
    tbl[11] = '{1'b0, 2'b00, 4'd0, 32'd0,         1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'd3, 32'h00500093, 32'd2};

    // Power-on reset.
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_LOAD;
    bus.cmd_addr  = 4'd0;
    bus.cmd_data  = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      string t;
      t = $sformatf("row%0d", i);
      step(tbl[i].v, cmd_op_e'(tbl[i].op), tbl[i].addr, tbl[i].data, t);
      chk1({t, ".t_ready"}, bus.cmd_ready, tbl[i].e_ready);
      chk1({t, ".t_iw"},    instruction_write, tbl[i].e_iw);
      chk1({t, ".t_run"},   run_pc, tbl[i].e_run);
      chk1({t, ".t_mrn"},   mem_reset_n, tbl[i].e_mrn);
      chk1({t, ".t_busy"},  busy, tbl[i].e_busy);
      chk1({t, ".t_done"},  done, tbl[i].e_done);
      chk1({t, ".t_err"},   err, tbl[i].e_err);
      chk32({t, ".t_iaddr"}, {28'd0, instruction_addr}, {28'd0, tbl[i].e_iaddr});
      chk32({t, ".t_idata"}, instruction_data, tbl[i].e_idata);
      chk32({t, ".t_cc"},    cycle_count, tbl[i].e_cc);
    end

    // A: RUN N=5 runs exactly five cycles, done follows and holds.
    step(1'b1, OP_RUN, 4'd0, 32'd5, "A");
    highs = int'(run_pc);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, OP_LOAD, 4'd0, 32'd0, "A");
      highs += int'(run_pc);
      if (i == 4) chk1("A.done6", done, 1'b1);
    end
    chk32("A.highs", 32'(highs), 32'd5);
    chk32("A.cc", cycle_count, 32'd5);
    chk1("A.done_held", done, 1'b1);

    // B: RUN N=100, STOP ten cycles after acceptance.
    step(1'b1, OP_RUN, 4'd0, 32'd100, "B");
    highs = int'(run_pc);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, OP_LOAD, 4'd0, 32'd0, "B");
      highs += int'(run_pc);
    end
    step(1'b1, OP_STOP, 4'd0, 32'd0, "B");
    chk32("B.highs", 32'(highs), 32'd10);
    chk1("B.run_low", run_pc, 1'b0);
    chk32("B.cc", cycle_count, 32'd10);
    chk1("B.done", done, 1'b1);
    step(1'b0, OP_LOAD, 4'd0, 32'd0, "B");
    chk32("B.cc_frozen", cycle_count, 32'd10);

    // C: STOP on the same edge the budget expires.
    step(1'b1, OP_RUN, 4'd0, 32'd3, "C");
    step(1'b0, OP_LOAD, 4'd0, 32'd0, "C");
    step(1'b0, OP_LOAD, 4'd0, 32'd0, "C");
    step(1'b1, OP_STOP, 4'd0, 32'd0, "C");
    chk32("C.cc", cycle_count, 32'd3);
    chk1("C.done", done, 1'b1);
    chk1("C.err", err, 1'b0);
    chk1("C.run", run_pc, 1'b0);

    // D: reset during the third cycle of an N=8 run.
    step(1'b1, OP_RUN, 4'd0, 32'd8, "D");
    step(1'b0, OP_LOAD, 4'd0, 32'd0, "D");
    step(1'b0, OP_LOAD, 4'd0, 32'd0, "D");
    chk1("D.running", run_pc, 1'b1);
    do_reset_mid("D");
    chk1("D.ready_after", bus.cmd_ready, 1'b1);
    chk1("D.busy_after", busy, 1'b0);

    // Randomized commands against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset_mid("rst");
      end else begin
        rop = cmd_op_e'($urandom_range(0, 3));
        rv  = ($urandom_range(0, 3) != 0);
        if (rop == OP_RUN) rd = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 10));
        else rd = $urandom;
        step(rv, rop, 4'($urandom), rd, "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
